mips_multicycle_controller: RTL and testbench

//   Control-unit FSM for the multicycle MIPS datapath. Decodes Op/Funct and drives

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_alu_decoder.sv | 24 ++
 rtl/mips_multicycle_controller.sv | 147 ++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcodes, Funct codes and control select codes
package mc_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
        S_JUMP    = 4'd11,
        S_BNEX    = 4'd12
`else
        S_JUMP    = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational R-type Funct to ALUControl decode
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_funct)
            FN_ADD:  o_alu_control = ALU_ADD;
            FN_SUB:  o_alu_control = ALU_SUB;
            FN_AND:  o_alu_control = ALU_AND;
            FN_OR:   o_alu_control = ALU_OR;
            FN_NOR:  o_alu_control = ALU_NOR;
            FN_SLT:  o_alu_control = ALU_SLT;
            FN_SLL:  o_alu_control = ALU_SLL;
            FN_SRL:  o_alu_control = ALU_SRL;
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multicycle MIPS control FSM (MC_BNE_EN adds bne)
module mips_multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [3:0]         ALUControl,
    output logic [STATE_W-1:0] dbg_state
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_rtype_alu;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_branch_ne;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

    mc_alu_decoder u_alu_dec (
        .i_funct       (Funct),
        .o_alu_control (w_rtype_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        PCSrc       = PCSRC_ALU;
        ALUControl  = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = S_BNEX;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            // Op is still held in the IR here, so it separates lw from sw
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_rtype_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PCSRC_ALUOUT;
                w_branch   = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEX: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                PCSrc       = PCSRC_ALUOUT;
                w_branch_ne = 1'b1;
            end
`endif
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset only suppresses the enables; the selects already sit at FETCH values
    assign PCEn     = ~rst & (w_pc_write | (w_branch & Zero) | (w_branch_ne & ~Zero));
    assign IRWrite  = ~rst & w_ir_write;
    assign RegWrite = ~rst & w_reg_write;
    assign MemWrite = ~rst & w_mem_write;

    assign dbg_state = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl;
    logic [3:0] dbg_state;

    typedef struct {
        string       tag;
        logic [19:0] word;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(state_t st, logic pcen, logic iord, logic mw, logic irw,
                                       logic rd, logic m2r, logic rw, logic sa,
                                       logic [1:0] sb, logic [1:0] pcs, logic [3:0] alu);
        return {4'(st), pcen, iord, mw, irw, rd, m2r, rw, sa, sb, pcs, alu};
    endfunction

    function automatic logic [3:0] alu_of(logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b1000;
            6'b000010: return 4'b1001;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [19:0] exp_for(state_t st, logic [5:0] fn, logic z);
        case (st)
            S_FETCH:   return mk(st, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);
            S_DECODE:  return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0010);
            S_MEMADR:  return mk(st, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0010);
            S_MEMRD:   return mk(st, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
            S_MEMWB:   return mk(st, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 4'b0010);
            S_MEMWR:   return mk(st, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
            S_EXECUTE: return mk(st, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu_of(fn));
            S_ALUWB:   return mk(st, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'b0010);
            S_BRANCH:  return mk(st, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'b0110);
            S_ADDIEX:  return mk(st, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0010);
            S_ADDIWB:  return mk(st, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0010);
            S_JUMP:    return mk(st, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0010);
`ifdef MC_BNE_EN
            S_BNEX:    return mk(st, ~z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'b0110);
`endif
            default:   return 20'hFFFFF;
        endcase
    endfunction

    function automatic logic [19:0] observed();
        return {dbg_state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSrc, ALUControl};
    endfunction

    task automatic push(string name, state_t st, logic [5:0] fn, logic z);
        exp_t e;
        e.tag  = $sformatf("%s/%s", name, st.name());
        e.word = exp_for(st, fn, z);
        q_exp.push_back(e);
    endtask

    task automatic push_reset(string name);
        exp_t e;
        e.tag  = name;
        e.word = mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);
        q_exp.push_back(e);
    endtask

    task automatic push_seq(string name, logic [5:0] op, logic [5:0] fn, logic z);
        push(name, S_FETCH, fn, z);
        push(name, S_DECODE, fn, z);
        case (op)
            6'b100011: begin
                push(name, S_MEMADR, fn, z); push(name, S_MEMRD, fn, z); push(name, S_MEMWB, fn, z);
            end
            6'b101011: begin
                push(name, S_MEMADR, fn, z); push(name, S_MEMWR, fn, z);
            end
            6'b000000: begin
                push(name, S_EXECUTE, fn, z); push(name, S_ALUWB, fn, z);
            end
            6'b001000: begin
                push(name, S_ADDIEX, fn, z); push(name, S_ADDIWB, fn, z);
            end
            6'b000100: push(name, S_BRANCH, fn, z);
            6'b000010: push(name, S_JUMP, fn, z);
`ifdef MC_BNE_EN
            6'b000101: push(name, S_BNEX, fn, z);
`endif
            default: ;
        endcase
    endtask

    task automatic check_one();
        exp_t        e;
        logic [19:0] obs;
        #1;
        if (q_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed empty queue, required an entry");
        end else begin
            e   = q_exp.pop_front();
            obs = observed();
            n_tests++;
            assert (obs === e.word) else begin
                n_fail++;
                $error("FAIL %s: observed %05h required %05h", e.tag, obs, e.word);
            end
        end
    endtask

    task automatic check_n(int n);
        for (int i = 0; i < n; i++) begin
            check_one();
            @(negedge clk);
        end
    endtask

    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, logic z);
        Op    = op;
        Funct = fn;
        Zero  = z;
        push_seq(name, op, fn, z);
        check_n(q_exp.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] functs [8];
        functs = '{6'b100000, 6'b100100, 6'b100101, 6'b100111,
                   6'b101010, 6'b000000, 6'b000010, 6'b111111};

        repeat (3) @(posedge clk);
        @(negedge clk);
        push_reset("reset_hold");
        check_one();
        rst = 1'b0;

        run_instr("lw", 6'b100011, 6'b000000, 1'b0);
        run_instr("r_sub", 6'b000000, 6'b100010, 1'b0);
        foreach (functs[i])
            run_instr($sformatf("r_fn%06b", functs[i]), 6'b000000, functs[i], 1'b0);
        run_instr("beq_taken", 6'b000100, 6'b111111, 1'b1);
        run_instr("beq_not", 6'b000100, 6'b000000, 1'b0);
        run_instr("sw", 6'b101011, 6'b000000, 1'b0);
        run_instr("j", 6'b000010, 6'b000000, 1'b0);
        run_instr("addi", 6'b001000, 6'b100010, 1'b0);
        run_instr("illegal", 6'b111111, 6'b000000, 1'b1);
        run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0);
        run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1);

        Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
        push_seq("lw_abort", 6'b100011, 6'd0, 1'b0);
        check_n(3);
        check_one();
        q_exp.delete();
        #2 rst = 1'b1;
        push_reset("abort_async");
        check_one();
        @(negedge clk);
        push_reset("abort_held");
        check_one();
        rst = 1'b0;
        run_instr("lw_restart", 6'b100011, 6'b000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
